// File: rtl/pin_entry_buffer_if.sv
// Keypad-to-lock bus for the PIN entry buffer.
// The master side is the keypad decoder and lock stage; the slave side is the buffer.
interface pin_entry_buffer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic [2:0] count;
    logic       entry_valid;
    logic       entry_error;
    logic       timeout;

    modport master (
        output key_valid, key_code,
        input  digit1, digit2, digit3, digit4, count, entry_valid, entry_error, timeout
    );

    modport slave (
        input  key_valid, key_code,
        output digit1, digit2, digit3, digit4, count, entry_valid, entry_error, timeout
    );
endinterface

// File: rtl/pin_entry_buffer.sv
// PIN entry buffer: collects keypad digits into a 4-digit PIN with backspace,
// clear, enter and an inter-key timeout. All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no digits buffered (count = 0)
// S_ENTRY | partial entry (count 1..3), timer running
// S_FULL  | 4 digits buffered, not submitted, timer running
// S_DONE  | submitted, digits held for the lock stage
module pin_entry_buffer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    pin_entry_buffer_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_FULL, S_DONE} state_t;

    state_t          r_state,  w_state;
    logic [3:0][3:0] r_digits, w_digits;
    logic [2:0]      r_count,  w_count;
    logic [TW-1:0]   r_timer,  w_timer;
    logic            r_valid,  w_valid;
    logic            r_error,  w_error;
    logic            r_tmo,    w_tmo;

    logic            w_key_acc;
    logic [1:0]      w_bs_pos;

    // Reserved codes 0xD-0xF are not keys at all: they neither act nor restart the timer.
    assign w_key_acc = bus.key_valid && (bus.key_code <= 4'hC);
    // Last filled position; count=4 wraps the 2-bit index to 3 as intended.
    assign w_bs_pos  = r_count[1:0] - 2'd1;

    // Register stage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_digits <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_digits <= w_digits;
            r_count  <= w_count;
            r_timer  <= w_timer;
            r_valid  <= w_valid;
            r_error  <= w_error;
            r_tmo    <= w_tmo;
        end
    end

    // Next-state, buffer update, timer and pulse decode.
    always_comb begin
        w_state  = r_state;
        w_digits = r_digits;
        w_count  = r_count;
        w_timer  = r_timer;
        w_valid  = 1'b0;
        w_error  = 1'b0;
        w_tmo    = 1'b0;

        if (w_key_acc) begin
            // An accepted key always wins over a coincident timer expiry.
            w_timer = '0;
            if (bus.key_code <= 4'h9) begin
                case (r_state)
                    S_IDLE, S_ENTRY: begin
                        w_digits[r_count[1:0]] = bus.key_code;
                        w_count = r_count + 3'd1;
                        w_state = (r_count == 3'd3) ? S_FULL : S_ENTRY;
                    end
                    S_DONE: begin
                        w_digits    = '0;
                        w_digits[0] = bus.key_code;
                        w_count     = 3'd1;
                        w_state     = S_ENTRY;
                    end
                    default: ;
                endcase
            end else if (bus.key_code == 4'hA) begin
                case (r_state)
                    S_ENTRY, S_FULL: begin
                        w_digits[w_bs_pos] = 4'h0;
                        w_count = r_count - 3'd1;
                        w_state = (r_count == 3'd1) ? S_IDLE : S_ENTRY;
                    end
                    S_DONE: begin
                        w_digits = '0;
                        w_count  = '0;
                        w_state  = S_IDLE;
                    end
                    default: ;
                endcase
            end else if (bus.key_code == 4'hB) begin
                w_digits = '0;
                w_count  = '0;
                w_state  = S_IDLE;
            end else begin
                if (r_state == S_FULL || r_state == S_DONE) begin
                    w_valid = 1'b1;
                    w_state = S_DONE;
                end else begin
                    w_error  = 1'b1;
                    w_digits = '0;
                    w_count  = '0;
                    w_state  = S_IDLE;
                end
            end
        end else if (r_state == S_ENTRY || r_state == S_FULL) begin
            if (r_timer == C_TIMER_LAST) begin
                w_tmo    = 1'b1;
                w_digits = '0;
                w_count  = '0;
                w_timer  = '0;
                w_state  = S_IDLE;
            end else begin
                w_timer = r_timer + TW'(1);
            end
        end else begin
            w_timer = '0;
        end
    end

    assign bus.digit1      = r_digits[0];
    assign bus.digit2      = r_digits[1];
    assign bus.digit3      = r_digits[2];
    assign bus.digit4      = r_digits[3];
    assign bus.count       = r_count;
    assign bus.entry_valid = r_valid;
    assign bus.entry_error = r_error;
    assign bus.timeout     = r_tmo;
endmodule

// File: tb/tb_pin_entry_buffer.sv
// Bench for pin_entry_buffer: scenario tasks drive keys and check the buffer
// inline; expected pulses go into a queue that a negedge monitor pops.
module tb_pin_entry_buffer;
    localparam int TMO = 20;

    typedef struct packed {
        logic [1:0]  kind;   // 1 = entry_valid, 2 = entry_error, 3 = timeout
        logic [15:0] digits; // {digit1, digit2, digit3, digit4}
        logic [2:0]  count;
    } exp_t;

    logic clk;
    logic reset;
    pin_entry_buffer_if bus ();

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    pin_entry_buffer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digs();
        return {bus.digit1, bus.digit2, bus.digit3, bus.digit4};
    endfunction

    // Pulse monitor: every pulse must match the next queued expectation.
    initial begin
        exp_t e;
        logic [1:0] kind;
        forever begin
            @(negedge clk);
            if (bus.entry_valid || bus.entry_error || bus.timeout) begin
                kind = bus.entry_valid ? 2'd1 : (bus.entry_error ? 2'd2 : 2'd3);
                n_total++;
                if ((32'(bus.entry_valid) + 32'(bus.entry_error) + 32'(bus.timeout)) != 1) begin
                    n_bad++;
                    $display("FAIL pulse_overlap: v=%0b e=%0b t=%0b, required one-hot",
                             bus.entry_valid, bus.entry_error, bus.timeout);
                end
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: kind=%0d at %0t, required none", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    n_total++;
                    if (kind !== e.kind || digs() !== e.digits || bus.count !== e.count) begin
                        n_bad++;
                        $display("FAIL pulse_check: kind=%0d digits=%h count=%0d, required kind=%0d digits=%h count=%0d",
                                 kind, digs(), bus.count, e.kind, e.digits, e.count);
                    end
                end
            end
        end
    end

    // Called at a negedge; drives one key for one edge and returns at the next negedge.
    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.key_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] kind, input logic [15:0] d, input logic [2:0] c);
        exp_t e;
        e.kind = kind; e.digits = d; e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        repeat (3) @(negedge clk);
        bus.key_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (digs() !== 16'h0000 || bus.count !== 3'd0 ||
            {bus.entry_valid, bus.entry_error, bus.timeout} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_state: digits=%h count=%0d pulses=%b, required 0000/0/000",
                     digs(), bus.count, {bus.entry_valid, bus.entry_error, bus.timeout});
        end
    endtask

    task automatic test_full_entry();
        press(4'h5); press(4'h6); press(4'h7); press(4'h8);
        n_total++;
        if (digs() !== 16'h5678 || bus.count !== 3'd4) begin
            n_bad++;
            $display("FAIL full_before_enter: digits=%h count=%0d, required 5678/4", digs(), bus.count);
        end
        expect_pulse(2'd1, 16'h5678, 3'd4);
        press(4'hC);
        idle(2);
        n_total++;
        if (digs() !== 16'h5678 || bus.count !== 3'd4) begin
            n_bad++;
            $display("FAIL done_hold: digits=%h count=%0d, required 5678/4", digs(), bus.count);
        end
        // A lock programmed with 5,6,7,8 would unlock on these digits.
        n_total++;
        if (!(bus.digit1 == 4'd5 && bus.digit2 == 4'd6 && bus.digit3 == 4'd7 && bus.digit4 == 4'd8)) begin
            n_bad++;
            $display("FAIL lock_match: digits=%h, required 5678", digs());
        end
        press(4'hB);
    endtask

    task automatic test_short_enter();
        press(4'h1); press(4'h2); press(4'h3);
        expect_pulse(2'd2, 16'h0000, 3'd0);
        press(4'hC);
        n_total++;
        if (digs() !== 16'h0000 || bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL short_enter: digits=%h count=%0d, required 0000/0", digs(), bus.count);
        end
    endtask

    task automatic test_backspace();
        press(4'h5); press(4'h6); press(4'h9); press(4'hA);
        n_total++;
        if (digs() !== 16'h5600 || bus.count !== 3'd2) begin
            n_bad++;
            $display("FAIL backspace: digits=%h count=%0d, required 5600/2", digs(), bus.count);
        end
        press(4'h7); press(4'h8); press(4'h4);
        n_total++;
        if (digs() !== 16'h5678 || bus.count !== 3'd4) begin
            n_bad++;
            $display("FAIL fifth_digit: digits=%h count=%0d, required 5678/4", digs(), bus.count);
        end
        press(4'hA);
        n_total++;
        if (digs() !== 16'h5670 || bus.count !== 3'd3) begin
            n_bad++;
            $display("FAIL backspace_full: digits=%h count=%0d, required 5670/3", digs(), bus.count);
        end
        press(4'h8);
        press(4'hD);
        n_total++;
        if (digs() !== 16'h5678 || bus.count !== 3'd4) begin
            n_bad++;
            $display("FAIL reserved_key: digits=%h count=%0d, required 5678/4", digs(), bus.count);
        end
        expect_pulse(2'd1, 16'h5678, 3'd4);
        press(4'hC);
        press(4'hA);
        n_total++;
        if (digs() !== 16'h0000 || bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL backspace_done: digits=%h count=%0d, required 0000/0", digs(), bus.count);
        end
        press(4'hA);
        n_total++;
        if (bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL backspace_idle: count=%0d, required 0", bus.count);
        end
    endtask

    task automatic test_timeout();
        press(4'h1); press(4'h2);
        idle(TMO - 1);
        n_total++;
        if (bus.count !== 3'd2 || digs() !== 16'h1200) begin
            n_bad++;
            $display("FAIL timeout_early: digits=%h count=%0d, required 1200/2", digs(), bus.count);
        end
        expect_pulse(2'd3, 16'h0000, 3'd0);
        idle(1);
        n_total++;
        if (bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL timeout_clear: count=%0d, required 0", bus.count);
        end
        press(4'h1); press(4'h2);
        idle(TMO - 1);
        press(4'h3);
        idle(5);
        n_total++;
        if (digs() !== 16'h1230 || bus.count !== 3'd3) begin
            n_bad++;
            $display("FAIL key_on_expiry: digits=%h count=%0d, required 1230/3", digs(), bus.count);
        end
        press(4'hB);
        // A reserved code mid-wait must not restart the timer.
        press(4'h4);
        idle(10);
        press(4'hE);
        idle(TMO - 12);
        n_total++;
        if (bus.count !== 3'd1) begin
            n_bad++;
            $display("FAIL reserved_timer_early: count=%0d, required 1", bus.count);
        end
        expect_pulse(2'd3, 16'h0000, 3'd0);
        idle(1);
        n_total++;
        if (bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL reserved_timer: count=%0d, required 0", bus.count);
        end
    endtask

    task automatic test_done_new_entry();
        press(4'h5); press(4'h6); press(4'h7); press(4'h8);
        expect_pulse(2'd1, 16'h5678, 3'd4);
        press(4'hC);
        idle(TMO + 5);
        n_total++;
        if (digs() !== 16'h5678 || bus.count !== 3'd4) begin
            n_bad++;
            $display("FAIL done_no_timeout: digits=%h count=%0d, required 5678/4", digs(), bus.count);
        end
        press(4'h1);
        n_total++;
        if (digs() !== 16'h1000 || bus.count !== 3'd1) begin
            n_bad++;
            $display("FAIL done_new_digit: digits=%h count=%0d, required 1000/1", digs(), bus.count);
        end
        press(4'hB);
    endtask

    task automatic test_back_to_back();
        press(4'h9); press(4'h0); press(4'h3); press(4'h1);
        expect_pulse(2'd1, 16'h9031, 3'd4);
        press(4'hC);
        expect_pulse(2'd1, 16'h9031, 3'd4);
        press(4'hC);
        idle(2);
        press(4'hB);
    endtask

    task automatic test_reset_mid();
        press(4'h5); press(4'h6); press(4'h7);
        reset = 1'b0;
        press(4'hE);
        reset = 1'b1;
        idle(1);
        n_total++;
        if (digs() !== 16'h0000 || bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid_entry: digits=%h count=%0d, required 0000/0", digs(), bus.count);
        end
        press(4'h2); press(4'h4); press(4'h6); press(4'h8);
        expect_pulse(2'd1, 16'h2468, 3'd4);
        press(4'hC);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        press(4'hC);
        n_total++;
        if (digs() !== 16'h0000 || bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_in_done: digits=%h count=%0d, required 0000/0", digs(), bus.count);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        @(negedge clk);
        test_reset();
        test_full_entry();
        test_short_enter();
        test_backspace();
        test_timeout();
        test_done_new_entry();
        test_back_to_back();
        test_reset_mid();
        idle(3);
        // Reset-in-DONE followed by enter in IDLE produces one error pulse.
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_pulse: %0d expected pulse(s) never seen, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // The final enter in test_reset_mid happens in IDLE; queue its error pulse in time.
    initial begin
        wait (reset === 1'b0 && n_total > 20 && dut.r_state == 2'd3);
        expect_pulse(2'd2, 16'h0000, 3'd0);
    end
endmodule

// File: doc/pin_entry_buffer.md
Name: pin_entry_buffer

Overview:
Upstream keypad-entry stage for the app lock comparator. Collects serial key presses from the keypad decoder into a 4-digit PIN buffer. Supports backspace, clear, enter and an inter-key timeout. On a valid enter it presents digit1..digit4 plus a one-cycle entry_valid strobe to the lock, which compares them against set1..set4.

Parameters:
TIMEOUT_CYCLES, 1000, idle clock cycles allowed between accepted keys before a partial entry is discarded (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
key_valid  input  1  one-cycle strobe, key_code valid this cycle
key_code  input  4  0x0-0x9 digit; 0xA backspace; 0xB clear; 0xC enter; 0xD-0xF reserved
digit1  output  4  first digit entered
digit2  output  4  second digit entered
digit3  output  4  third digit entered
digit4  output  4  fourth digit entered
count  output  3  number of digits currently buffered, 0..4
entry_valid  output  1  one-cycle pulse: complete 4-digit PIN presented
entry_error  output  1  one-cycle pulse: enter pressed with fewer than 4 digits
timeout  output  1  one-cycle pulse: partial or full entry discarded by timeout

Behaviour:
- Reset (reset=0 at rising clk): digit1..4=0, count=0, entry_valid=0, entry_error=0, timeout=0, timer=0, state=IDLE. Reset mid-entry or in DONE discards everything.
- All outputs are registered. A key sampled at edge N takes effect after edge N. Pulses are high for exactly the cycle following edge N.
- A key is accepted only when key_valid=1. Reserved codes 0xD-0xF are ignored entirely: no state change, timer not restarted.
- States:
  - IDLE: count=0.
  - ENTRY: count 1..3.
  - FULL: count=4, not yet submitted.
  - DONE: submitted, digits held.
- Digit key:
  - IDLE/ENTRY: write to position count+1 (digit1 first), count+1. Go to ENTRY, or to FULL when count reaches 4.
  - FULL: ignored (no overwrite, no error). Timer still restarts.
  - DONE: start a new entry. digit1=key, digit2..4=0, count=1, state ENTRY.
- Backspace:
  - ENTRY/FULL: clear position count to 0, count-1. Go to IDLE if count reaches 0, else ENTRY.
  - IDLE: no-op.
  - DONE: behaves as clear.
- Clear: any state -> all digits 0, count=0, IDLE. No pulse.
- Enter:
  - FULL: entry_valid pulse, state DONE. Digits and count held unchanged through DONE.
  - DONE: entry_valid pulses again (resubmit same PIN).
  - IDLE/ENTRY: entry_error pulse, digits cleared, count=0, IDLE.
- Timeout timer:
  - Runs only in ENTRY or FULL; held at 0 in IDLE and DONE.
  - Reset to 0 on every accepted (non-reserved) key.
  - Increments each cycle without an accepted key.
  - When it reaches TIMEOUT_CYCLES: timeout pulse, digits cleared, count=0, IDLE, timer=0.
- Simultaneous accepted key and timer expiry: key wins, timer restarts, no timeout pulse.
- Pulses never overlap: at most one of entry_valid/entry_error/timeout is high in any cycle.
- Digit outputs are valid and stable from the entry_valid cycle until the next accepted key or reset. The lock stage may sample on the entry_valid cycle or any later cycle in DONE.
- Widths: count 3 bits, saturates at 4 by construction. Timer width clog2(TIMEOUT_CYCLES+1); no wrap.

Test Plan:
1. Reset held low, then keys 5,6,7,8, enter -> digit1..4=5,6,7,8, count=4, entry_valid high exactly one cycle after enter, then DONE. Lock with set=5,6,7,8 asserts unlocked=1.
2. Keys 1,2,3, enter -> entry_error one cycle, digits all 0, count=0, entry_valid never asserted.
3. Keys 5,6,9, backspace, 7,8,4 (5th digit), enter -> digit3=7, digit4=8 (5th digit ignored), entry_valid one pulse.
4. TIMEOUT_CYCLES=20: keys 1,2, then idle 20 cycles -> timeout pulse on the 20th idle cycle, count=0. Repeat with a key on the expiry cycle -> no timeout, count=3.
5. In DONE with 5,6,7,8, press 1 -> digit1=1, digit2..4=0, count=1. Enter twice from a fresh full entry -> two entry_valid pulses.
6. Keys 5,6,7, reset=0 one cycle, key_valid with 0xE -> all outputs 0, state IDLE, no pulses.
